complex_divide_unit: RTL and testbench
======================================

// Module: complex_divide_unit
// PURPOSE
//  Sequential complex divider: result = operand_a / operand_b, all values complex_t (Q3.13, 16-bit re/im).
//  Computes num = a*conj(b), den = |b|^2, then runs two restoring dividers (re, im) in parallel over a shared den.
//  Inverse companion to the pipelined complex multiplier; used for normalisation/equalisation in the datapath.
//  Valid/ready on both sides; one operation in flight at a time.
// PARAMETERS
//  FRAC_BITS  13  fractional bits of complex_t; must equal the package constant (elaboration assert)
//  DATA_W     16  width of complex_t components; ITER = DATA_W-1 = 15 divide iterations (localparam)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       reset, asynchronous, active-low
//  in_valid       in   1       operands valid
//  in_ready       out  1       unit idle, can accept operands
//  operand_a      in   32      complex_t dividend
//  operand_b      in   32      complex_t divisor
//  out_valid      out  1       result valid, held until accepted
//  out_ready      in   1       downstream accepts result
//  result         out  32      complex_t quotient
//  div_by_zero    out  1       den==0 for this result
//  saturated      out  1       either component clamped
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, saturated=0; internal regs cleared.
//  Reset mid-operation discards the operation; no stale result after release.
//  FSM: IDLE -> MUL -> PREP -> DIV(x15) -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid&&in_ready capture a,b -> MUL. in_ready=0 in all other states.
//   MUL: register ar*br, ai*bi, ai*br, ar*bi, br*br, bi*bi (signed 16x16 -> 32).
//   PREP: num_re = ar*br + ai*bi, num_im = ai*br - ar*bi (33-bit signed); den = br^2 + bi^2 (32-bit unsigned).
//    Store sign and |num| per component. Overflow per component if |num| >= den<<2 (|q| >= 4.0).
//    den==0 -> skip DIV, go to DONE with result=0, div_by_zero=1, saturated=0.
//   DIV: restoring division of |num|<<FRAC_BITS by den, one quotient bit per cycle MSB-first, 15 cycles.
//   DONE: out_valid=1; result, flags stable until out_ready; on out_valid&&out_ready -> IDLE.
//  Latency: accept at edge E0; out_valid high after edge E17 (17 cycles); den==0 case after E3.
//  Throughput: one result per 18 cycles minimum (DONE->IDLE costs one cycle; no same-cycle re-accept).
//  Arithmetic: q_mag = floor(|num|*2^13 / den) (truncation toward zero); component = sign ? -q_mag : q_mag.
//   Overflow clamps to 0x7FFF (positive) or 0x8000 (negative), sets saturated; each component independent.
//   Zero numerator gives 0 regardless of sign (never 0x8000 unless overflow).
//  in_valid while busy is ignored (not captured); operands need not stay stable after acceptance.
// STRUCTURE
//  Package (fixed_point_pkg): complex_t, DATA_W, FRAC_BITS, Q_MAX=16'h7FFF, Q_MIN=16'h8000 constants.
//  Sub-module: cdu_restoring_div (unsigned serial divider, start/busy/done, 45-bit dividend, 32-bit divisor,
//   15-bit quotient), instantiated twice (re, im) sharing den and start; top holds FSM, products, sign/sat logic.
// TESTING
//  a=(0x2000,0) b=(0x2000,0) -> result (0x2000,0x0000), flags 0, out_valid exactly 17 cycles after accept.
//  a=(0x2000,0x2000) b=(0x0000,0x2000) -> (0x2000,0xE000) i.e. 1-j.
//  a=(0x2000,0) b=(0x6000,0) -> (0x0AAA,0); a=(0xE000,0) same b -> (0xF556,0) (truncation toward zero).
//  a=(0x4000,0) b=(0x1000,0) -> (0x7FFF,0), saturated=1; a=(0xC000,0) -> (0x8000,0), saturated=1.
//  b=(0,0), any a -> result 0, div_by_zero=1, out_valid after 3 cycles.
//  out_ready low 5 cycles in DONE: result stable, in_ready=0, in_valid pulses ignored; rst_n low mid-DIV -> IDLE.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Fixed-point complex types and constants shared by the complex arithmetic units.
package fixed_point_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 13;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_PREP, S_DIV, S_DONE} cdu_state_t;

    // Apply the numerator sign to a quotient magnitude, clamping on overflow.
    function automatic logic [DATA_W-1:0] sat_component(input logic [DATA_W-2:0] q_mag,
                                                         input logic neg, input logic ovf);
        logic [DATA_W-1:0] mag;
        mag = {1'b0, q_mag};
        if (ovf) return neg ? Q_MIN : Q_MAX;
        return neg ? -mag : mag;
    endfunction
endpackage

// File: rtl/cdu_restoring_div.sv
// Unsigned serial restoring divider: one quotient bit per cycle, MSB first.
module cdu_restoring_div #(
    parameter int DVD_W = 45,
    parameter int DVS_W = 32,
    parameter int Q_W   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);
    localparam int CNT_W = $clog2(Q_W);

    logic [DVS_W-1:0] rem_q, dvs_q, diff;
    logic [Q_W-1:0]   low_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DVS_W:0]   trial;
    logic             take;

    // The caller guarantees quotient < 2^Q_W, so the upper dividend bits start below divisor
    // and the restored remainder always fits DVS_W bits.
    always_comb begin
        trial = {rem_q, low_q[Q_W-1]};
        take  = (trial >= {1'b0, dvs_q});
        diff  = trial[DVS_W-1:0] - dvs_q;
    end

    assign done = busy && (cnt_q == CNT_W'(Q_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            low_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem_q    <= DVS_W'(dividend[DVD_W-1:Q_W]);
            low_q    <= dividend[Q_W-1:0];
            dvs_q    <= divisor;
            cnt_q    <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            rem_q    <= take ? diff : trial[DVS_W-1:0];
            low_q    <= {low_q[Q_W-2:0], 1'b0};
            quotient <= {quotient[Q_W-2:0], take};
            cnt_q    <= cnt_q + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/complex_divide_unit.sv
// Sequential complex divider: result = operand_a / operand_b via a*conj(b) / |b|^2.
module complex_divide_unit
    import fixed_point_pkg::*;
#(
    parameter int FRAC_BITS = 13,
    parameter int DATA_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  complex_t   operand_a,
    input  complex_t   operand_b,
    output logic       out_valid,
    input  logic       out_ready,
    output complex_t   result,
    output logic       div_by_zero,
    output logic       saturated,
    output cdu_state_t state_dbg
);
    localparam int ITER   = DATA_W - 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int DVD_W  = PROD_W + FRAC_BITS;

    if (FRAC_BITS != fixed_point_pkg::FRAC_BITS || DATA_W != fixed_point_pkg::DATA_W) begin : g_param_chk
        $error("complex_divide_unit: FRAC_BITS/DATA_W must match fixed_point_pkg");
    end

    cdu_state_t state, state_nx;
    complex_t   a_q, b_q;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri, p_br2, p_bi2;
    logic signed [PROD_W:0]   num_re, num_im;
    logic [PROD_W:0]          mag_re, mag_im;
    logic [PROD_W-1:0]        den_c;
    logic                     neg_re, neg_im, ovf_re, ovf_im, dz_q;
    logic                     div_start, busy_re, busy_im, done_re, done_im;
    logic [ITER-1:0]          q_re, q_im;

    always_comb begin
        num_re    = (PROD_W+1)'(p_rr) + (PROD_W+1)'(p_ii);
        num_im    = (PROD_W+1)'(p_ir) - (PROD_W+1)'(p_ri);
        mag_re    = num_re[PROD_W] ? $unsigned(-num_re) : $unsigned(num_re);
        mag_im    = num_im[PROD_W] ? $unsigned(-num_im) : $unsigned(num_im);
        den_c     = $unsigned(p_br2) + $unsigned(p_bi2);
        div_start = (state == S_PREP) && (den_c != '0);
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready; in_ready is high
    // only in IDLE, and out_valid with result/flags holds steady in DONE until out_ready.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_MUL;
            S_MUL:  state_nx = S_PREP;
            S_PREP: state_nx = S_DIV;
            // A zero divisor never starts the dividers, so the idle dividers release DIV at once.
            S_DIV:  if ((done_re && done_im) || !(busy_re || busy_im)) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            p_rr   <= '0;
            p_ii   <= '0;
            p_ir   <= '0;
            p_ri   <= '0;
            p_br2  <= '0;
            p_bi2  <= '0;
            neg_re <= 1'b0;
            neg_im <= 1'b0;
            ovf_re <= 1'b0;
            ovf_im <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid) begin
                a_q <= operand_a;
                b_q <= operand_b;
            end
            if (state == S_MUL) begin
                p_rr  <= a_q.re * b_q.re;
                p_ii  <= a_q.im * b_q.im;
                p_ir  <= a_q.im * b_q.re;
                p_ri  <= a_q.re * b_q.im;
                p_br2 <= b_q.re * b_q.re;
                p_bi2 <= b_q.im * b_q.im;
            end
            if (state == S_PREP) begin
                neg_re <= num_re[PROD_W];
                neg_im <= num_im[PROD_W];
                dz_q   <= (den_c == '0);
                ovf_re <= (den_c != '0) && ({1'b0, mag_re} >= {den_c, 2'b00});
                ovf_im <= (den_c != '0) && ({1'b0, mag_im} >= {den_c, 2'b00});
            end
        end
    end

    cdu_restoring_div #(.DVD_W(DVD_W), .DVS_W(PROD_W), .Q_W(ITER)) u_div_re (
        .clk(clk), .rst_n(rst_n), .start(div_start),
        .dividend({mag_re[PROD_W-1:0], {FRAC_BITS{1'b0}}}), .divisor(den_c),
        .busy(busy_re), .done(done_re), .quotient(q_re)
    );

    cdu_restoring_div #(.DVD_W(DVD_W), .DVS_W(PROD_W), .Q_W(ITER)) u_div_im (
        .clk(clk), .rst_n(rst_n), .start(div_start),
        .dividend({mag_im[PROD_W-1:0], {FRAC_BITS{1'b0}}}), .divisor(den_c),
        .busy(busy_im), .done(done_im), .quotient(q_im)
    );

    always_comb begin
        in_ready    = (state == S_IDLE);
        out_valid   = (state == S_DONE);
        state_dbg   = state;
        result      = '0;
        div_by_zero = 1'b0;
        saturated   = 1'b0;
        if (state == S_DONE) begin
            div_by_zero = dz_q;
            saturated   = ovf_re || ovf_im;
            if (!dz_q) result = {sat_component(q_re, neg_re, ovf_re), sat_component(q_im, neg_im, ovf_im)};
        end
    end
endmodule

// File: tb/tb_complex_divide_unit.sv
// Directed bench for complex_divide_unit: vector table plus backpressure and mid-divide reset sequences.
module tb_complex_divide_unit;
    import fixed_point_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_dz;
        logic        exp_sat;
        int          exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    complex_t   operand_a = '0;
    complex_t   operand_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    complex_t   result;
    logic       div_by_zero;
    logic       saturated;
    cdu_state_t state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    vec_t vecs[16];

    complex_divide_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .div_by_zero(div_by_zero),
        .saturated(saturated), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic wait_done(output int lat, input string tag);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid low after %0d cycles, required high", tag, lat);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.a, v.b, tag);
        wait_done(lat, tag);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_result"}, result, v.exp_res);
        check({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, v.exp_dz});
        check({tag, "_saturated"}, {31'b0, saturated}, {31'b0, v.exp_sat});
        @(posedge clk);
        #1;
        check({tag, "_released"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 1'b0, 1'b0, 17};
        vecs[1]  = '{32'h2000_2000, 32'h0000_2000, 32'h2000_E000, 1'b0, 1'b0, 17};
        vecs[2]  = '{32'h2000_0000, 32'h6000_0000, 32'h0AAA_0000, 1'b0, 1'b0, 17};
        vecs[3]  = '{32'hE000_0000, 32'h6000_0000, 32'hF556_0000, 1'b0, 1'b0, 17};
        vecs[4]  = '{32'h4000_0000, 32'h1000_0000, 32'h7FFF_0000, 1'b0, 1'b1, 17};
        vecs[5]  = '{32'hC000_0000, 32'h1000_0000, 32'h8000_0000, 1'b0, 1'b1, 17};
        vecs[6]  = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 3};
        vecs[7]  = '{32'h7FFF_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 17};
        vecs[8]  = '{32'h8000_0000, 32'h2000_0000, 32'h8000_0000, 1'b0, 1'b1, 17};
        vecs[9]  = '{32'h4000_0800, 32'h1000_0000, 32'h7FFF_1000, 1'b0, 1'b1, 17};
        vecs[10] = '{32'hFFFF_0000, 32'h6000_0000, 32'h0000_0000, 1'b0, 1'b0, 17};
        vecs[11] = '{32'h0003_0000, 32'h0001_0000, 32'h6000_0000, 1'b0, 1'b0, 17};
        vecs[12] = '{32'h2000_0000, 32'h2000_2000, 32'h1000_F000, 1'b0, 1'b0, 17};
        vecs[13] = '{32'h2000_0000, 32'h0000_2000, 32'h0000_E000, 1'b0, 1'b0, 17};
        vecs[14] = '{32'h1000_1000, 32'h1000_1000, 32'h2000_0000, 1'b0, 1'b0, 17};
        vecs[15] = '{32'h0000_0000, 32'hE000_0000, 32'h0000_0000, 1'b0, 1'b0, 17};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {30'b0, div_by_zero, saturated}, 32'd0);
        check("reset_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: result held 5 cycles, busy-time in_valid pulses must be ignored
        out_ready = 1'b0;
        start_op(vecs[2].a, vecs[2].b, "hold");
        wait_done(lat, "hold");
        check("hold_latency", 32'(lat), 32'd17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            operand_a = 32'h4000_0000;
            operand_b = 32'h1000_0000;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("hold%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold%0d_result", i), result, 32'h0AAA_0000);
            check($sformatf("hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_accept_out_valid", {31'b0, out_valid}, 32'd0);
        check("hold_accept_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("hold_no_capture", {30'b0, out_valid, in_ready}, 32'd1);

        // Reset in the middle of the divide
        start_op(vecs[0].a, vecs[0].b, "rst");
        repeat (8) @(posedge clk);
        #1;
        check("rst_in_div", {29'b0, state_dbg}, {29'b0, S_DIV});
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_stale", {31'b0, seen}, 32'd0);
        run_vec(vecs[3], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
